// File: rtl/fpga_cfg_pkg.sv
// Shared types and default geometry for the fpga configuration path.
// Used by the loader and by the fabric top and its benches.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STROBE,
    ST_SETTLE,
    ST_RUN
  } cfg_state_t;

  localparam int CFG_WORD_W    = 224;
  localparam int CFG_NUM_WORDS = 43;
  localparam int CFG_SETTLE    = 10;

endpackage

// File: rtl/cfg_settle_timer.sv
// Loadable down-counter that stops at zero; done_o is high while the count is zero.
// Reused wherever a fixed post-event release delay is needed.
module cfg_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fpga_config_loader.sv
// Streams configuration words into the fabric one column per strobe, waits a
// settle interval, then enables the fabric flip-flops and reports ready.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_W        = CFG_WORD_W,
  parameter int NUM_WORDS     = CFG_NUM_WORDS,
  parameter int SETTLE_CYCLES = CFG_SETTLE
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_W-1:0]    cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [WORD_W-1:0]    configs_in,
  output logic [NUM_WORDS-1:0] configs_en,
  output logic                 ff_en,
  output logic                 rdy,
  output logic                 busy,
  output cfg_state_t           dbg_state
);

  // Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
  // cfg_ready is high only in WAIT and the source holds cfg_data until then.

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]     SETTLE_VAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_WORDS-1:0] EN_ONE     = NUM_WORDS'(1);

  cfg_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]    cin_q, cin_d;
  logic [NUM_WORDS-1:0] cen_q, cen_d;
  logic                 ff_q, ff_d;
  logic                 rdy_q, rdy_d;
  logic                 tmr_load;
  logic                 tmr_done;

  cfg_settle_timer #(.CNT_W(CNT_W)) u_settle (
    .clk_i      (clock),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_VAL),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cin_d    = cin_q;
    cen_d    = '0;
    ff_d     = ff_q;
    rdy_d    = rdy_q;
    tmr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ff_d  = 1'b0;
        rdy_d = 1'b0;
        if (start) begin
          idx_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The strobe is registered here so it lines up with the captured word.
        if (cfg_valid) begin
          cin_d   = cfg_data;
          cen_d   = EN_ONE << idx_q;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (idx_q == LAST_IDX) begin
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          ff_d    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rdy_d = ff_q;
        if (start) begin
          ff_d    = 1'b0;
          rdy_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cin_q   <= '0;
      cen_q   <= '0;
      ff_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      cen_q   <= cen_d;
      ff_q    <= ff_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cfg_ready  = (state_q == ST_WAIT);
  assign busy       = (state_q == ST_WAIT) || (state_q == ST_STROBE) || (state_q == ST_SETTLE);
  assign configs_in = cin_q;
  assign configs_en = cen_q;
  assign ff_en      = ff_q;
  assign rdy        = rdy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench: a small 4-word/3-settle loader for timing scenarios and a
// default-geometry loader for a full 43-column load.
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  localparam int W = 224;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  // small instance: NUM_WORDS=4, SETTLE_CYCLES=3
  logic          s_start, s_valid, s_ready, s_ff, s_rdy, s_busy;
  logic [W-1:0]  s_data, s_cin;
  logic [3:0]    s_cen;
  cfg_state_t    s_state;

  // default instance: NUM_WORDS=43, SETTLE_CYCLES=10
  logic          d_start, d_valid, d_ready, d_ff, d_rdy, d_busy;
  logic [W-1:0]  d_data, d_cin;
  logic [42:0]   d_cen;
  cfg_state_t    d_state;

  fpga_config_loader #(.WORD_W(W), .NUM_WORDS(4), .SETTLE_CYCLES(3)) dut_small (
    .clock(clock), .rst(rst), .start(s_start), .cfg_data(s_data), .cfg_valid(s_valid),
    .cfg_ready(s_ready), .configs_in(s_cin), .configs_en(s_cen), .ff_en(s_ff),
    .rdy(s_rdy), .busy(s_busy), .dbg_state(s_state)
  );

  fpga_config_loader dut_def (
    .clock(clock), .rst(rst), .start(d_start), .cfg_data(d_data), .cfg_valid(d_valid),
    .cfg_ready(d_ready), .configs_in(d_cin), .configs_en(d_cen), .ff_en(d_ff),
    .rdy(d_rdy), .busy(d_busy), .dbg_state(d_state)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] words_small [4];
  logic [W-1:0] words_def [43];
  logic [W-1:0] exp_q [$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_small_reset(input string tag);
    check({tag, "_cin"},   s_cin, '0);
    check({tag, "_cen"},   s_cen, '0);
    check({tag, "_ff"},    s_ff, 0);
    check({tag, "_rdy"},   s_rdy, 0);
    check({tag, "_ready"}, s_ready, 0);
    check({tag, "_busy"},  s_busy, 0);
    check({tag, "_state"}, s_state, ST_IDLE);
  endtask

  // ---------------- driver: one load on the small instance ----------------
  // Edge 0 samples start. Word i is accepted at edge 2i+1, shifted by gap_len
  // for words at or after gap_word; ff_en rises at 2*4+3+gap_len.
  task automatic run_small(input string tag, input int gap_word, input int gap_len,
                           input int extra1, input int extra2, input int rst_edge,
                           input int end_edge);
    int acc [4];
    int ffe, w, gap_lo, gap_hi;
    logic [3:0] exp_en;
    for (int i = 0; i < 4; i++)
      acc[i] = 2 * i + 1 + ((gap_len > 0 && i >= gap_word) ? gap_len : 0);
    ffe = 11 + gap_len;
    if (gap_len > 0) begin
      gap_lo = acc[gap_word] - gap_len;
      gap_hi = acc[gap_word] - 1;
    end else begin
      gap_lo = -10;
      gap_hi = -10;
    end
    w = 0;
    s_start = 1'b1;
    s_valid = 1'b1;
    s_data  = words_small[0];
    tick();
    s_start = 1'b0;
    check({tag, "_e0_ready"}, s_ready, 1);
    check({tag, "_e0_busy"},  s_busy, 1);
    check({tag, "_e0_ff"},    s_ff, 0);
    check({tag, "_e0_rdy"},   s_rdy, 0);
    check({tag, "_e0_cen"},   s_cen, '0);
    for (int e = 1; e <= end_edge; e++) begin
      s_valid = !(e >= gap_lo && e <= gap_hi);
      s_data  = (w < 4) ? words_small[w] : {W{1'b1}};
      s_start = (e == extra1) || (e == extra2);
      rst     = (e == rst_edge);
      tick();
      s_start = 1'b0;
      rst     = 1'b0;
      if (e == rst_edge) begin
        check_small_reset({tag, "_midrst"});
        return;
      end
      exp_en = '0;
      for (int i = 0; i < 4; i++) if (acc[i] == e) exp_en[i] = 1'b1;
      check($sformatf("%s_cen_e%0d", tag, e), s_cen, exp_en);
      if (exp_en != '0) begin
        check($sformatf("%s_cin_e%0d", tag, e), s_cin, words_small[w]);
        w++;
      end
      if (e >= gap_lo && e <= gap_hi)
        check($sformatf("%s_gap_ready_e%0d", tag, e), s_ready, 1);
      check($sformatf("%s_ff_e%0d", tag, e),  s_ff,  (e >= ffe));
      check($sformatf("%s_rdy_e%0d", tag, e), s_rdy, (e >= ffe + 1));
    end
  endtask

  // ---------------- default geometry load with scoreboard ----------------
  task automatic run_default();
    logic [42:0] one, exp_en;
    int cols [43];
    logic [W-1:0] exp_w;
    one = 43'd1;
    for (int i = 0; i < 43; i++) begin
      for (int k = 0; k < 7; k++) words_def[i][k*32 +: 32] = $urandom;
      exp_q.push_back(words_def[i]);
      cols[i] = 0;
    end
    d_start = 1'b1;
    d_valid = 1'b1;
    d_data  = words_def[0];
    tick();
    d_start = 1'b0;
    for (int e = 1; e <= 98; e++) begin
      d_data = (((e - 1) / 2) < 43) ? words_def[(e - 1) / 2] : '0;
      tick();
      exp_en = ((e % 2 == 1) && e <= 85) ? (one << ((e - 1) / 2)) : '0;
      check($sformatf("def_cen_e%0d", e), d_cen, exp_en);
      if (d_cen != '0) begin
        for (int i = 0; i < 43; i++) if (d_cen[i]) cols[i]++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check($sformatf("def_cin_e%0d", e), d_cin, exp_w);
      end
      check($sformatf("def_ff_e%0d", e),  d_ff,  (e >= 96));
      check($sformatf("def_rdy_e%0d", e), d_rdy, (e >= 97));
    end
    for (int i = 0; i < 43; i++) check($sformatf("def_col%0d_once", i), cols[i], 1);
    check("def_queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 4; i++) words_small[i] = W'(8'hA0 + i);
    s_start = 1'b0; s_valid = 1'b0; s_data = '0;
    d_start = 1'b0; d_valid = 1'b0; d_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_small_reset("reset");
    check("reset_def_state", d_state, ST_IDLE);
    check("reset_def_cen",   d_cen, '0);

    // basic load, held in RUN through edge 19
    run_small("basic", -1, 0, -1, -1, -1, 19);
    // start at edge 20 of the previous load: reconfiguration from RUN
    run_small("reconf", -1, 0, -1, -1, -1, 14);
    // cfg_valid low for 5 cycles before word 2
    run_small("bp", 2, 5, -1, -1, -1, 18);
    // start while busy has no effect
    run_small("busystart", -1, 0, 2, 9, -1, 14);
    // reset during the load, then a fresh load
    run_small("rstmid", -1, 0, -1, -1, 4, 14);
    run_small("afterrst", -1, 0, -1, -1, -1, 14);

    run_default();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Synthesizable configuration sequencer for the `fpga` fabric. It replaces the simulation-only bitstream loader in front of `fpga`.
- Accepts configuration words over a valid/ready stream and writes them one per column, using one-hot `configs_en` strobes.
- Waits a fixed settle interval after the last write, then enables the fabric flip-flops (`ff_en`) and signals `rdy`.
- Sits between a bitstream source (ROM, UART, host FIFO) and the `configs_in` / `configs_en` / `ff_en` pins of `fpga`.

## Interface
- `WORD_W`, 224: width of one configuration word, equal to `fpga` `configs_in`.
- `NUM_WORDS`, 43: number of config words per bitstream, equal to `fpga` `configs_en` width.
- `SETTLE_CYCLES`, 10: idle cycles between the last strobe and `ff_en` rising; minimum 1.
- `clock`  in  1  single clock; everything is registered on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a (re)configuration.
- `cfg_data`  in  WORD_W  configuration word.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  loader accepts a word this cycle.
- `configs_in`  out  WORD_W  word driven to the fabric.
- `configs_en`  out  NUM_WORDS  one-hot write strobe to the fabric.
- `ff_en`  out  1  fabric flip-flop enable.
- `rdy`  out  1  configuration complete and fabric running.
- `busy`  out  1  a load is in progress (states WAIT, STROBE, SETTLE).

## Operation
- State machine states: IDLE, WAIT, STROBE, SETTLE, RUN.
- IDLE:
  - All outputs are 0.
  - `start` → WAIT; the word index `idx` is cleared to 0.
- WAIT:
  - `cfg_ready`=1.
  - When `cfg_valid`&&`cfg_ready`, `configs_in` ← `cfg_data`, then → STROBE.
  - Otherwise the state holds with no timeout.
- STROBE:
  - `cfg_ready`=0.
  - `configs_en` = 1<<`idx` for exactly this one cycle; `configs_in` is stable throughout.
  - If `idx`==NUM_WORDS-1 → SETTLE with the settle counter loaded to SETTLE_CYCLES-1.
  - Otherwise `idx`++ and → WAIT.
- SETTLE:
  - The counter decrements each cycle.
  - When the counter reaches 0 → RUN, with `ff_en` registered to 1 on that transition.
- RUN:
  - `ff_en`=1.
  - `rdy` rises one cycle after `ff_en`, then both hold.
  - `start` in RUN is a reconfiguration: `ff_en` and `rdy` clear on the same edge, `idx`=0, → WAIT.
- Outside the STROBE state, `configs_en` is all zeros; no column is ever written twice per load.
- `configs_in` keeps the last accepted word until the next accept; it is never cleared except by reset.
- `start` is ignored in WAIT, STROBE and SETTLE.
- `cfg_valid` outside WAIT is ignored; the source must hold the word until it sees `cfg_ready`.
- `idx` is `$clog2(NUM_WORDS)` bits wide and never wraps: the STROBE state checks the terminal count before incrementing.
- The settle counter is `$clog2(SETTLE_CYCLES+1)` bits wide.

## Timing
- Reset (`rst`=1 at an edge): state → IDLE; `configs_in`=0, `configs_en`=0, `ff_en`=0, `rdy`=0, `cfg_ready`=0, `busy`=0, `idx`=0.
- Reset mid-load: the same values apply on the next edge. Partial fabric configuration is abandoned; the source must restart the stream.
- Edge numbering: `start` is sampled at edge 0. With `cfg_valid` held high:
  - Word i is accepted at edge 2i+1.
  - `configs_en[i]` is high between edges 2i+1 and 2i+2.
  - `ff_en` rises at edge 2·NUM_WORDS+SETTLE_CYCLES.
  - `rdy` rises one edge after `ff_en`.
- Throughput: at most one word per 2 cycles. Each cycle of `cfg_valid`=0 in WAIT adds exactly one cycle.
- All outputs are registered except `cfg_ready` and `busy`, which decode the state register directly. There is no combinational path from any input to any output.

## Structure
- Package `fpga_cfg_pkg` holds:
  - the state enum `cfg_state_t`;
  - the default constants `CFG_WORD_W`=224, `CFG_NUM_WORDS`=43 and `CFG_SETTLE`=10, shared with the `fpga` top and its benches.
- Sub-module `cfg_settle_timer`: a loadable down-counter with a done flag. It is reused later for post-reset release delays.
- Target size: 150–250 lines of RTL in total.

## Test plan
- Basic load: NUM_WORDS=4, SETTLE_CYCLES=3, `cfg_valid` always 1, words 0xA0..0xA3, `start` at edge 0.
  - `configs_en` shows 0001, 0010, 0100, 1000 at edges 1, 3, 5, 7, with `configs_in` equal to 0xA0..0xA3 in the matching strobe cycles.
  - `ff_en` rises at edge 11 and `rdy` at edge 12.
- Backpressure: the same setup, but `cfg_valid` drops for 5 cycles before word 2.
  - `cfg_ready` stays 1 and `configs_en` stays 0 during the gap.
  - `ff_en` rises at edge 16.
- Reset mid-load: assert `rst` at edge 4 (during the load).
  - At the next edge all outputs are 0 and the state is IDLE.
  - A fresh `start` reproduces the basic-load timing exactly.
- `start` while busy: pulse `start` at edges 2 and 9.
  - There is no effect: the strobe sequence and `ff_en` timing are identical to the basic load.
- Reconfigure: `start` in RUN at edge 20.
  - `ff_en` and `rdy` are 0 from edge 20, and `configs_en[0]` strobes at edge 21.
- Defaults: NUM_WORDS=43, SETTLE_CYCLES=10, random 224-bit words.
  - The scoreboard shows each of the 43 columns strobed exactly once with the matching word.
  - `ff_en` rises at edge 96.
